// File: rtl/mips_mc_ctrl_hs.sv
// mips_mc_ctrl_hs: multicycle MIPS control FSM with a req/ready memory
// handshake (or fixed-latency mode), extended ISA decode and timeout fault.
module mips_mc_ctrl_hs #(
    parameter int MEM_HANDSHAKE = 1,
    parameter int MEM_WAIT      = 1,
    parameter int TIMEOUT       = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       branch,
    output logic       branch_ne,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic [1:0] alu_src_a,
    output logic [2:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [1:0] alu_op,
    output logic       imm_funct_sel,
    output logic [5:0] imm_funct,
    output logic       illegal,
    output logic       fault,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_IEXEC  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_JAL    = 4'd11,
        S_JR     = 4'd12,
        S_FAULT  = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam bit         HS       = (MEM_HANDSHAKE != 0);
    localparam logic [7:0] WAIT_LIM = 8'(MEM_WAIT);
    localparam logic [7:0] TO_LIM   = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nx;
    logic [7:0] cnt;
    logic       fault_q;
    logic       mem_state;
    logic       accept;
    logic       timeout;
    logic       is_shift;
    logic       r_alu;

    // R-type function class from the stable IR funct field
    always_comb begin
        is_shift = (funct == FN_SLL) || (funct == FN_SRL) ||
                   (funct == FN_SRA);
        r_alu    = is_shift ||
                   (funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR,
                                  FN_XOR, FN_NOR, FN_SLT});
    end

    // Memory-state accept and not-ready timeout detection
    always_comb begin
        mem_state = (state == S_FETCH) || (state == S_MEMRD) ||
                    (state == S_MEMWR);
        accept    = HS ? mem_ready : (cnt == WAIT_LIM);
        timeout   = HS && mem_state && !mem_ready && (cnt >= TO_LIM);
    end

    // State, wait counter and sticky fault registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            cnt     <= '0;
            fault_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (state_nx != state) begin
                cnt <= '0;
            end else if (mem_state && (!HS || !mem_ready) &&
                         cnt != 8'hFF) begin
                cnt <= cnt + 8'd1;
            end
            if (state_nx == S_FAULT) begin
                fault_q <= 1'b1;
            end
        end
    end

    // Next-state and control decode; everything held low during rst
    always_comb begin
        state_nx      = state;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        branch        = 1'b0;
        branch_ne     = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 2'b00;
        mem_to_reg    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 3'b000;
        pc_src        = 2'b00;
        alu_op        = 2'b00;
        imm_funct_sel = 1'b0;
        imm_funct     = 6'b000000;
        illegal       = 1'b0;
        fault         = 1'b0;
        state_dbg     = 4'd0;
        if (!rst) begin
            fault     = fault_q;
            state_dbg = state;
            unique case (state)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = 3'b001;
                    if (accept) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_nx = S_DECODE;
                    end else if (timeout) begin
                        state_nx = S_FAULT;
                    end
                end
                S_DECODE: begin
                    alu_src_b = 3'b011;
                    case (opcode)
                        OP_RTYPE: begin
                            if (r_alu) begin
                                state_nx = S_REXEC;
                            end else if (funct == FN_JR) begin
                                state_nx = S_JR;
                            end else begin
                                illegal  = 1'b1;
                                state_nx = S_FETCH;
                            end
                        end
                        OP_LW, OP_SW: state_nx = S_MEMADR;
                        OP_ADDI, OP_ANDI, OP_ORI,
                        OP_XORI, OP_SLTI, OP_LUI: state_nx = S_IEXEC;
                        OP_BEQ, OP_BNE: state_nx = S_BRANCH;
                        OP_J:   state_nx = S_JUMP;
                        OP_JAL: state_nx = S_JAL;
                        default: begin
                            illegal  = 1'b1;
                            state_nx = S_FETCH;
                        end
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 3'b010;
                    state_nx  = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    if (accept) begin
                        state_nx = S_MEMWB;
                    end else if (timeout) begin
                        state_nx = S_FAULT;
                    end
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 2'b01;
                    state_nx   = S_FETCH;
                end
                S_MEMWR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    iord    = 1'b1;
                    if (accept) begin
                        state_nx = S_FETCH;
                    end else if (timeout) begin
                        state_nx = S_FAULT;
                    end
                end
                S_REXEC: begin
                    alu_op    = 2'b10;
                    alu_src_a = is_shift ? 2'b10 : 2'b01;
                    state_nx  = S_ALUWB;
                end
                S_IEXEC: begin
                    alu_src_a     = 2'b01;
                    alu_op        = 2'b10;
                    imm_funct_sel = 1'b1;
                    case (opcode)
                        OP_ADDI: begin
                            alu_src_b = 3'b010;
                            imm_funct = FN_ADD;
                        end
                        OP_SLTI: begin
                            alu_src_b = 3'b010;
                            imm_funct = FN_SLT;
                        end
                        OP_ANDI: begin
                            alu_src_b = 3'b100;
                            imm_funct = FN_AND;
                        end
                        OP_ORI: begin
                            alu_src_b = 3'b100;
                            imm_funct = FN_OR;
                        end
                        OP_XORI: begin
                            alu_src_b = 3'b100;
                            imm_funct = FN_XOR;
                        end
                        OP_LUI: begin
                            alu_src_b = 3'b101;
                            imm_funct = FN_ADD;
                        end
                        default: ;
                    endcase
                    state_nx = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_write     = 1'b1;
                    reg_dst       = (opcode == OP_RTYPE) ? 2'b01 : 2'b00;
                    imm_funct_sel = (opcode != OP_RTYPE);
                    state_nx      = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a = 2'b01;
                    alu_op    = 2'b01;
                    pc_src    = 2'b01;
                    branch    = (opcode == OP_BEQ);
                    branch_ne = (opcode == OP_BNE);
                    state_nx  = S_FETCH;
                end
                S_JUMP: begin
                    pc_src   = 2'b10;
                    pc_write = 1'b1;
                    state_nx = S_FETCH;
                end
                S_JAL: begin
                    pc_src     = 2'b10;
                    pc_write   = 1'b1;
                    reg_write  = 1'b1;
                    reg_dst    = 2'b10;
                    mem_to_reg = 2'b10;
                    state_nx   = S_FETCH;
                end
                S_JR: begin
                    pc_src   = 2'b11;
                    pc_write = 1'b1;
                    state_nx = S_FETCH;
                end
                S_FAULT: state_nx = S_FAULT;
                default: state_nx = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mc_ctrl_hs.sv
// tb_mips_mc_ctrl_hs: self-checking bench for mips_mc_ctrl_hs.
// Table vectors, hand-written corner sequences and a randomized model run.
`timescale 1ns/1ps
module tb_mips_mc_ctrl_hs;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic       branch_ne;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_src_a;
        logic [2:0] alu_src_b;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
        logic       imm_funct_sel;
        logic [5:0] imm_funct;
        logic       illegal;
        logic       fault;
        logic [3:0] state_dbg;
    } ctl_t;

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [3:0]  n;
        logic [23:0] seq;
    } vec_t;

    localparam int TO_H = 4;

    localparam int C_LW = 0, C_SW = 1, C_RALU = 2, C_SHIFT = 3;
    localparam int C_JR = 4, C_IMM = 5, C_BEQ = 6, C_BNE = 7;
    localparam int C_J = 8, C_JAL = 9, C_ILL = 10;

    localparam logic [5:0] RFN [7] = '{6'h20, 6'h22, 6'h24, 6'h25,
                                       6'h26, 6'h27, 6'h2A};
    localparam logic [5:0] SFN [3] = '{6'h00, 6'h02, 6'h03};
    localparam logic [5:0] IOP [6] = '{6'h08, 6'h0C, 6'h0D,
                                       6'h0E, 6'h0A, 6'h0F};
    localparam logic [2:0] IB  [6] = '{3'b010, 3'b100, 3'b100,
                                       3'b100, 3'b010, 3'b101};
    localparam logic [5:0] IFN [6] = '{6'h20, 6'h24, 6'h25,
                                       6'h26, 6'h2A, 6'h20};
    localparam logic [5:0] OPS [18] = '{6'h00, 6'h00, 6'h00, 6'h23,
                                        6'h2B, 6'h08, 6'h0C, 6'h0D,
                                        6'h0E, 6'h0A, 6'h0F, 6'h04,
                                        6'h05, 6'h02, 6'h03, 6'h3F,
                                        6'h20, 6'h01};
    localparam logic [5:0] FNS [14] = '{6'h20, 6'h22, 6'h24, 6'h25,
                                        6'h26, 6'h27, 6'h2A, 6'h00,
                                        6'h02, 6'h03, 6'h08, 6'h09,
                                        6'h18, 6'h3F};

    logic       clk = 1'b0;
    logic       rst_h, rst_f, rdy_h, rdy_f;
    logic [5:0] op_h, fn_h, op_f, fn_f;
    wire [33:0] h_v;
    wire [33:0] f_v;
    int         nvec = 0;
    int         nerr = 0;

    always #5 clk = ~clk;

    mips_mc_ctrl_hs #(
        .MEM_HANDSHAKE(1), .MEM_WAIT(1), .TIMEOUT(TO_H)
    ) dut_hs (
        .clk(clk), .rst(rst_h), .opcode(op_h), .funct(fn_h),
        .mem_ready(rdy_h),
        .mem_req(h_v[33]), .mem_we(h_v[32]), .iord(h_v[31]),
        .ir_write(h_v[30]), .pc_write(h_v[29]), .branch(h_v[28]),
        .branch_ne(h_v[27]), .reg_write(h_v[26]),
        .reg_dst(h_v[25:24]), .mem_to_reg(h_v[23:22]),
        .alu_src_a(h_v[21:20]), .alu_src_b(h_v[19:17]),
        .pc_src(h_v[16:15]), .alu_op(h_v[14:13]),
        .imm_funct_sel(h_v[12]), .imm_funct(h_v[11:6]),
        .illegal(h_v[5]), .fault(h_v[4]), .state_dbg(h_v[3:0])
    );

    mips_mc_ctrl_hs #(
        .MEM_HANDSHAKE(0), .MEM_WAIT(2), .TIMEOUT(15)
    ) dut_fx (
        .clk(clk), .rst(rst_f), .opcode(op_f), .funct(fn_f),
        .mem_ready(rdy_f),
        .mem_req(f_v[33]), .mem_we(f_v[32]), .iord(f_v[31]),
        .ir_write(f_v[30]), .pc_write(f_v[29]), .branch(f_v[28]),
        .branch_ne(f_v[27]), .reg_write(f_v[26]),
        .reg_dst(f_v[25:24]), .mem_to_reg(f_v[23:22]),
        .alu_src_a(f_v[21:20]), .alu_src_b(f_v[19:17]),
        .pc_src(f_v[16:15]), .alu_op(f_v[14:13]),
        .imm_funct_sel(f_v[12]), .imm_funct(f_v[11:6]),
        .illegal(f_v[5]), .fault(f_v[4]), .state_dbg(f_v[3:0])
    );

    // Instruction class from the supported-ISA lists
    function automatic int cls(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) begin
            for (int i = 0; i < 3; i++) if (fn == SFN[i]) return C_SHIFT;
            for (int i = 0; i < 7; i++) if (fn == RFN[i]) return C_RALU;
            if (fn == 6'h08) return C_JR;
            return C_ILL;
        end
        for (int i = 0; i < 6; i++) if (op == IOP[i]) return C_IMM;
        if (op == 6'h23) return C_LW;
        if (op == 6'h2B) return C_SW;
        if (op == 6'h04) return C_BEQ;
        if (op == 6'h05) return C_BNE;
        if (op == 6'h02) return C_J;
        if (op == 6'h03) return C_JAL;
        return C_ILL;
    endfunction

    // Phase sequence of one instruction (first phase in the top nibble)
    function automatic logic [23:0] plan_of(input int c);
        case (c)
            C_LW:            return 24'h012340;
            C_SW:            return 24'h012500;
            C_RALU, C_SHIFT: return 24'h016800;
            C_IMM:           return 24'h017800;
            C_BEQ, C_BNE:    return 24'h019000;
            C_J:             return 24'h01A000;
            C_JAL:           return 24'h01B000;
            C_JR:            return 24'h01C000;
            default:         return 24'h010000;
        endcase
    endfunction

    function automatic int plan_len(input int c);
        case (c)
            C_LW:                              return 5;
            C_SW, C_RALU, C_SHIFT, C_IMM:      return 4;
            C_BEQ, C_BNE, C_J, C_JAL, C_JR:    return 3;
            default:                           return 2;
        endcase
    endfunction

    // Expected control word for a phase, instruction and accept
    function automatic ctl_t exp_ctl(input logic [3:0] st,
                                     input logic [5:0] op,
                                     input logic [5:0] fn,
                                     input logic acc);
        ctl_t e;
        int   c;
        e = '0;
        e.state_dbg = st;
        c = cls(op, fn);
        case (st)
            4'd0: begin
                e.mem_req = 1'b1; e.alu_src_b = 3'b001;
                e.ir_write = acc; e.pc_write = acc;
            end
            4'd1: begin
                e.alu_src_b = 3'b011; e.illegal = (c == C_ILL);
            end
            4'd2: begin
                e.alu_src_a = 2'b01; e.alu_src_b = 3'b010;
            end
            4'd3: begin
                e.mem_req = 1'b1; e.iord = 1'b1;
            end
            4'd4: begin
                e.reg_write = 1'b1; e.mem_to_reg = 2'b01;
            end
            4'd5: begin
                e.mem_req = 1'b1; e.mem_we = 1'b1; e.iord = 1'b1;
            end
            4'd6: begin
                e.alu_op = 2'b10;
                e.alu_src_a = (c == C_SHIFT) ? 2'b10 : 2'b01;
            end
            4'd7: begin
                e.alu_src_a = 2'b01; e.alu_op = 2'b10;
                e.imm_funct_sel = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    if (op == IOP[i]) begin
                        e.alu_src_b = IB[i]; e.imm_funct = IFN[i];
                    end
                end
            end
            4'd8: begin
                e.reg_write = 1'b1;
                e.reg_dst = (op == 6'h00) ? 2'b01 : 2'b00;
                e.imm_funct_sel = (op != 6'h00);
            end
            4'd9: begin
                e.alu_src_a = 2'b01; e.alu_op = 2'b01; e.pc_src = 2'b01;
                e.branch = (c == C_BEQ); e.branch_ne = (c == C_BNE);
            end
            4'd10: begin
                e.pc_src = 2'b10; e.pc_write = 1'b1;
            end
            4'd11: begin
                e.pc_src = 2'b10; e.pc_write = 1'b1; e.reg_write = 1'b1;
                e.reg_dst = 2'b10; e.mem_to_reg = 2'b10;
            end
            4'd12: begin
                e.pc_src = 2'b11; e.pc_write = 1'b1;
            end
            4'd15: e.fault = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    task automatic chk(input string nm, input logic [33:0] act,
                       input logic [33:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic pick(output logic [5:0] op, output logic [5:0] fn);
        op = OPS[$urandom_range(0, 17)];
        fn = (op == 6'h00) ? FNS[$urandom_range(0, 13)] : 6'($urandom);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t        tbl [18];
        logic [3:0]  st;
        logic [5:0]  cop, cfn;
        logic [23:0] plan;
        int          k, w, plen, fcnt;
        bit          flt, dorst, mem;

        tbl[0]  = '{6'h23, 6'h00, 4'd6, 24'h012340};
        tbl[1]  = '{6'h2B, 6'h00, 4'd5, 24'h012500};
        tbl[2]  = '{6'h00, 6'h20, 4'd5, 24'h016800};
        tbl[3]  = '{6'h00, 6'h00, 4'd5, 24'h016800};
        tbl[4]  = '{6'h00, 6'h27, 4'd5, 24'h016800};
        tbl[5]  = '{6'h0D, 6'h3F, 4'd5, 24'h017800};
        tbl[6]  = '{6'h0F, 6'h00, 4'd5, 24'h017800};
        tbl[7]  = '{6'h0A, 6'h11, 4'd5, 24'h017800};
        tbl[8]  = '{6'h04, 6'h00, 4'd4, 24'h019000};
        tbl[9]  = '{6'h05, 6'h00, 4'd4, 24'h019000};
        tbl[10] = '{6'h02, 6'h00, 4'd4, 24'h01A000};
        tbl[11] = '{6'h03, 6'h00, 4'd4, 24'h01B000};
        tbl[12] = '{6'h00, 6'h08, 4'd4, 24'h01C000};
        tbl[13] = '{6'h3F, 6'h00, 4'd3, 24'h010000};
        tbl[14] = '{6'h00, 6'h18, 4'd3, 24'h010000};
        tbl[15] = '{6'h0C, 6'h00, 4'd5, 24'h017800};
        tbl[16] = '{6'h0E, 6'h00, 4'd5, 24'h017800};
        tbl[17] = '{6'h08, 6'h00, 4'd5, 24'h017800};

        rst_h = 1'b1; rdy_h = 1'b0; op_h = '0; fn_h = '0;
        rst_f = 1'b1; rdy_f = 1'b0; op_f = '0; fn_f = '0;

        // reset forces every output low
        @(negedge clk);
        chk("reset_hs", h_v, '0);
        chk("reset_fx", f_v, '0);
        tick();

        // table vectors, zero-wait memory
        for (int v = 0; v < 18; v++) begin
            rst_h = 1'b1; rdy_h = 1'b1;
            tick();
            rst_h = 1'b0; op_h = tbl[v].op; fn_h = tbl[v].fn;
            for (int i = 0; i < int'(tbl[v].n); i++) begin
                st = tbl[v].seq[23-4*i -: 4];
                @(negedge clk);
                chk($sformatf("vec%0d_c%0d", v, i), h_v,
                    exp_ctl(st, op_h, fn_h, 1'b1));
                tick();
            end
        end

        // sw waits three not-ready cycles in MEMWR
        rst_h = 1'b1; rdy_h = 1'b1; op_h = 6'h2B; fn_h = '0;
        tick();
        rst_h = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rdy_h = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) rdy_h = 1'b1;
            @(negedge clk);
            chk($sformatf("sw_wait%0d", i), h_v,
                exp_ctl(4'd5, op_h, fn_h, rdy_h));
            tick();
        end
        @(negedge clk);
        chk("sw_done", h_v, exp_ctl(4'd0, op_h, fn_h, 1'b1));

        // FETCH timeout then recovery through rst
        rst_h = 1'b1; rdy_h = 1'b0; op_h = 6'h23;
        tick();
        rst_h = 1'b0;
        for (int i = 0; i < TO_H; i++) begin
            @(negedge clk);
            chk($sformatf("to_fetch%0d", i), h_v,
                exp_ctl(4'd0, op_h, fn_h, 1'b0));
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            rdy_h = i[0];
            @(negedge clk);
            chk($sformatf("to_fault%0d", i), h_v,
                exp_ctl(4'd15, op_h, fn_h, 1'b0));
            tick();
        end
        rst_h = 1'b1;
        @(negedge clk);
        chk("to_rst", h_v, '0);
        tick();
        rst_h = 1'b0; rdy_h = 1'b0;
        @(negedge clk);
        chk("to_after", h_v, exp_ctl(4'd0, op_h, fn_h, 1'b0));

        // ready in the last allowed cycle is accepted, no fault
        rst_h = 1'b1;
        tick();
        rst_h = 1'b0;
        for (int i = 0; i < TO_H - 1; i++) tick();
        rdy_h = 1'b1;
        @(negedge clk);
        chk("to_edge_acc", h_v, exp_ctl(4'd0, op_h, fn_h, 1'b1));
        tick();
        @(negedge clk);
        chk("to_edge_dec", h_v, exp_ctl(4'd1, op_h, fn_h, 1'b1));

        // rst in MEMRD aborts the load
        rst_h = 1'b1; rdy_h = 1'b1; op_h = 6'h23;
        tick();
        rst_h = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rdy_h = 1'b0;
        @(negedge clk);
        chk("ab_memrd", h_v, exp_ctl(4'd3, op_h, fn_h, 1'b0));
        tick();
        rst_h = 1'b1;
        @(negedge clk);
        chk("ab_rst", h_v, '0);
        tick();
        rst_h = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("ab_fetch%0d", i), h_v,
                exp_ctl(4'd0, op_h, fn_h, 1'b0));
            tick();
        end

        // fixed-latency instance: memory phases last three cycles
        rst_f = 1'b0;
        for (int n = 0; n < 3; n++) begin
            op_f = (n == 0) ? 6'h23 : (n == 1) ? 6'h2B : 6'h00;
            fn_f = 6'h25;
            plan = plan_of(cls(op_f, fn_f));
            for (int p = 0; p < plan_len(cls(op_f, fn_f)); p++) begin
                st = plan[23-4*p -: 4];
                mem = (st == 4'd0) || (st == 4'd3) || (st == 4'd5);
                for (int d = 0; d < (mem ? 3 : 1); d++) begin
                    rdy_f = 1'($urandom);
                    @(negedge clk);
                    chk($sformatf("fx%0d_s%0d_d%0d", n, st, d), f_v,
                        exp_ctl(st, op_f, fn_f, d == 2));
                    tick();
                end
            end
        end

        // randomized run against the phase model
        rst_h = 1'b1;
        tick();
        pick(cop, cfn);
        plan = plan_of(cls(cop, cfn));
        plen = plan_len(cls(cop, cfn));
        k = 0; w = 0; flt = 0; fcnt = 0;
        for (int c = 0; c < 3000; c++) begin
            dorst = (flt && fcnt >= 3) || ($urandom_range(0, 99) == 0);
            rst_h = dorst; op_h = cop; fn_h = cfn;
            rdy_h = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (dorst) begin
                chk("rnd_rst", h_v, '0);
                pick(cop, cfn);
                plan = plan_of(cls(cop, cfn));
                plen = plan_len(cls(cop, cfn));
                k = 0; w = 0; flt = 0; fcnt = 0;
            end else if (flt) begin
                chk("rnd_fault", h_v, exp_ctl(4'd15, cop, cfn, 1'b0));
                fcnt++;
            end else begin
                st = plan[23-4*k -: 4];
                mem = (st == 4'd0) || (st == 4'd3) || (st == 4'd5);
                chk($sformatf("rnd%0d_s%0d", c, st), h_v,
                    exp_ctl(st, cop, cfn, rdy_h));
                if (mem && !rdy_h) begin
                    w++;
                    if (w == TO_H) begin
                        flt = 1; fcnt = 0;
                    end
                end else begin
                    w = 0; k++;
                    if (k == plen) begin
                        pick(cop, cfn);
                        plan = plan_of(cls(cop, cfn));
                        plen = plan_len(cls(cop, cfn));
                        k = 0;
                    end
                end
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mips_mc_ctrl_hs.md
Name: mips_mc_ctrl_hs

Overview:
Next-generation multicycle MIPS control FSM. Its memory interface is a req/ready handshake with a configurable wait mode, replacing the fixed "repeat" cycles used for non-ideal memory. It adds bne, jr, lui, nor, zero-extended logical immediates, illegal-opcode detection and a memory timeout fault. It drives the existing multicycle datapath muxes and enables, and feeds alu_op/imm_funct to the existing alu_decoder.

Parameters:
MEM_HANDSHAKE, 1, 1 = memory states wait for mem_ready; 0 = fixed latency, mem_ready ignored.
MEM_WAIT, 1, fixed-mode extra cycles; each memory state lasts MEM_WAIT+1 cycles (legal range 0..15).
TIMEOUT, 15, handshake mode: maximum consecutive not-ready cycles in one memory state before fault (legal range 1..255).

Ports:
clk  in  1  clock
rst  in  1  reset
opcode  in  6  IR[31:26], stable from DECODE through completion
funct  in  6  IR[5:0]
mem_ready  in  1  memory accepts/completes the current access this cycle
mem_req  out  1  memory access request
mem_we  out  1  write strobe, valid with mem_req
iord  out  1  0 = PC address, 1 = ALUOut address
ir_write  out  1  IR load enable
pc_write  out  1  unconditional PC load
branch  out  1  PC load if zero (beq)
branch_ne  out  1  PC load if !zero (bne)
reg_write  out  1  register file write
reg_dst  out  2  00 rt, 01 rd, 10 $31
mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC
alu_src_a  out  2  00 PC, 01 rs, 10 shamt
alu_src_b  out  3  000 rt, 001 const 4, 010 sign-ext imm, 011 sign-ext imm<<2, 100 zero-ext imm, 101 imm<<16
pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 rs
alu_op  out  2  00 add, 01 sub, 10 use funct
imm_funct_sel  out  1  1 = alu_decoder takes imm_funct instead of funct
imm_funct  out  6  synthesized funct for I-type ops
illegal  out  1  one-cycle pulse on unsupported opcode/funct
fault  out  1  sticky memory timeout
state_dbg  out  4  current state encoding

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On rst: state <= FETCH, wait/timeout counter <= 0, fault <= 0. While rst is high, all outputs are forced to 0. rst mid-access aborts it; no enable is asserted in the rst cycle.
- Outputs are a Moore decode of state plus opcode/funct. The only exceptions are FETCH ir_write/pc_write and wait-state exits, which are qualified by the accept condition. Any output not listed for a state is 0.
- Accept condition: handshake mode = mem_ready. Fixed mode = counter reaches MEM_WAIT. The counter clears on every state change.
- Encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, REXEC 6, IEXEC 7, ALUWB 8, BRANCH 9, JUMP 10, JAL 11, JR 12, FAULT 15.
- FETCH: mem_req=1, iord=0, alu_src_a=00, alu_src_b=001, alu_op=00, pc_src=00. On accept, assert ir_write=1 and pc_write=1 in the same cycle and go to DECODE; otherwise stay.
- DECODE: alu_src_a=00, alu_src_b=011, alu_op=00 (precomputes the branch target).
  - R-type (opcode 000000): funct in {100000,100010,100100,100101,100110,100111,101010,000000,000010,000011} goes to REXEC; funct 001000 goes to JR.
  - 100011 and 101011 go to MEMADR.
  - 001000, 001100, 001101, 001110, 001010, 001111 go to IEXEC.
  - 000100 and 000101 go to BRANCH; 000010 goes to JUMP; 000011 goes to JAL.
  - Anything else: illegal=1 for this cycle, next state FETCH (executed as NOP).
- MEMADR: alu_src_a=01, alu_src_b=010, alu_op=00. Next state MEMRD (lw) or MEMWR (sw).
- MEMRD: mem_req=1, iord=1. On accept go to MEMWB.
- MEMWB: reg_write=1, reg_dst=00, mem_to_reg=01. Next state FETCH.
- MEMWR: mem_req=1, mem_we=1, iord=1. On accept go to FETCH.
- REXEC: alu_op=10. For shifts (funct 000000/000010/000011) alu_src_a=10; otherwise alu_src_a=01. alu_src_b=000. Next state ALUWB.
- IEXEC: alu_src_a=01, alu_op=10, imm_funct_sel=1. Next state ALUWB.
  - alu_src_b: 010 for addi/slti, 100 for andi/ori/xori, 101 for lui.
  - imm_funct: addi 100000, andi 100100, ori 100101, xori 100110, slti 101010, lui 100000 (rs contribution is zeroed by the datapath for lui: alu_src_a=01 with rs field = 0 in lui encoding).
- ALUWB: reg_write=1, mem_to_reg=00, reg_dst=01 if opcode==0 else 00. imm_funct_sel is held as in IEXEC. Next state FETCH.
- BRANCH: alu_src_a=01, alu_src_b=000, alu_op=01, pc_src=01. branch=1 for beq, branch_ne=1 for bne. Next state FETCH.
- JUMP: pc_src=10, pc_write=1. Next state FETCH.
- JAL: pc_src=10, pc_write=1, reg_write=1, reg_dst=10, mem_to_reg=10 (PC already holds PC+4). Next state FETCH.
- JR: pc_src=11, pc_write=1. Next state FETCH.
- Timeout (handshake mode only): in FETCH/MEMRD/MEMWR the counter increments each not-ready cycle. When it reaches TIMEOUT with mem_ready=0, go to FAULT. A mem_ready arriving in that same cycle wins (it is accepted, no fault). The counter saturates and never wraps.
- FAULT: all enables 0, fault=1. The state holds until rst.
- Latency with zero-wait memory: lw 5, sw 4, R/I-type 4, beq/bne/j/jal/jr 3 cycles.

Test Plan:
- Handshake mode, mem_ready tied 1, opcode 100011 → states 0,1,2,3,4,0; ir_write and pc_write high together exactly once; reg_write high only in state 4 with mem_to_reg=01.
- Handshake mode, MEMWR with mem_ready low for 3 cycles then high → mem_req and mem_we held high for 4 cycles, then state 0; fault stays 0.
- Handshake mode, TIMEOUT=4, FETCH with mem_ready held 0 → fault=1 and state_dbg=15 after 4 not-ready cycles; all enables 0 until rst; after rst, state 0 and fault 0.
- MEM_HANDSHAKE=0, MEM_WAIT=2, mem_ready toggling randomly → FETCH lasts exactly 3 cycles; ir_write asserted only on cycle 3.
- Opcode 000101 → branch_ne=1, branch=0, pc_src=01, alu_op=01. Opcode 001101 → imm_funct=100101, alu_src_b=100, then reg_dst=00 write. Funct 001000 → pc_src=11 with pc_write.
- Opcode 111111 → illegal pulse of exactly 1 cycle in DECODE, no enables, return to FETCH. rst asserted during MEMRD → next state FETCH, no reg_write.
